// File: rtl/chan_scan_4to1.sv
// chan_scan_4to1: scan sequencer for a 4:1 channel mux.
//
// On an accepted start pulse the enabled channels (chan_en mask) are visited
// in ascending order. For each channel, sel is driven and held for DWELL
// settle cycles. mux_y is then sampled and presented on a valid/ready port.
// done pulses for one cycle when the scan finishes. A start with an empty
// mask also pulses done, but produces no beats.
//
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   start     - scan request, ignored while busy
//   chan_en   - channel enable mask, captured when start is accepted
//   mux_y     - mux output being sampled
//   sel       - channel select driven to the mux
//   out_data  - sampled channel value
//   out_chan  - channel index of out_data
//   out_valid - out_data/out_chan valid
//   out_ready - consumer accept
//   busy      - scan in progress
//   done      - single-cycle scan-complete pulse
module chan_scan_4to1 #(
    parameter int unsigned DWIDTH = 4,
    parameter int unsigned DWELL  = 2    // legal range 1..15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        chan_en,
    input  logic [DWIDTH-1:0] mux_y,
    output logic [1:0]        sel,
    output logic [DWIDTH-1:0] out_data,
    output logic [1:0]        out_chan,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(DWELL - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        mask_q, mask_d;
    logic [1:0]        sel_q, sel_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic [1:0]        chan_q, chan_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [1:0]        first_ch;
    logic [1:0]        next_ch;
    logic              next_found;

    // Lowest enabled channel in the incoming mask, and the next enabled
    // channel above the current one in the latched mask. Disabled
    // channels are skipped here, so no cycles are spent on them.
    always_comb begin
        first_ch   = '0;
        next_ch    = '0;
        next_found = 1'b0;
        for (int unsigned i = 4; i > 0; i--) begin
            if (chan_en[i-1]) begin
                first_ch = 2'(i - 1);
            end
        end
        for (int unsigned i = 0; i < 4; i++) begin
            if (mask_q[i] && (i > 32'(sel_q)) && !next_found) begin
                next_ch    = 2'(i);
                next_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        sel_d   = sel_q;
        data_d  = data_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (chan_en != 4'b0000) begin
                        mask_d  = chan_en;
                        sel_d   = first_ch;
                        cnt_d   = CNT_LOAD;
                        busy_d  = 1'b1;
                        state_d = SETTLE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    data_d  = mux_y;
                    chan_d  = sel_q;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    if (next_found) begin
                        sel_d   = next_ch;
                        cnt_d   = CNT_LOAD;
                        state_d = SETTLE;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mask_q  <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sel       = sel_q;
    assign out_data  = data_q;
    assign out_chan  = chan_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_chan_scan_4to1.sv
module tb_chan_scan_4to1;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] chan_en;
    logic [3:0] mux_y;
    logic [1:0] sel;
    logic [3:0] out_data;
    logic [1:0] out_chan;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;

    // Mux inputs: a is variable, b/c/d fixed.
    logic [3:0] a;
    logic [3:0] sel_seen;
    int unsigned n_total;
    int unsigned n_bad;

    chan_scan_4to1 #(
        .DWIDTH(4),
        .DWELL (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .chan_en  (chan_en),
        .mux_y    (mux_y),
        .sel      (sel),
        .out_data (out_data),
        .out_chan (out_chan),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done)
    );

    always_comb begin
        case (sel)
            2'd0:    mux_y = a;
            2'd1:    mux_y = 4'b0010;
            2'd2:    mux_y = 4'b0100;
            default: mux_y = 4'b1000;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample 1 time unit later; record sels driven while busy.
    task automatic tick();
        @(posedge clk);
        #1;
        if (busy) sel_seen = sel_seen | (4'b0001 << sel);
    endtask

    task automatic start_scan(input logic [3:0] en);
        chan_en = en;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Wait (bounded) for out_valid, then check the presented beat.
    task automatic wait_beat(input string tag, input logic [1:0] ch, input logic [3:0] dat);
        int unsigned n;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_chan"},  32'(out_chan),  32'(ch));
        chk({tag, "_data"},  32'(out_data),  32'(dat));
        chk({tag, "_sel"},   32'(sel),       32'(ch));
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        chan_en   = 4'b0000;
        out_ready = 1'b1;
        a         = 4'b0001;
        sel_seen  = 4'b0000;

        // Reset state
        #12;
        chk("rst_sel",   32'(sel),       32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_chan",  32'(out_chan),  32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        rst_n = 1'b1;
        tick();

        // Full scan, exact timing: valid at +2, beats every 3 cycles
        start_scan(4'b1111);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_sel0", 32'(sel),  32'd0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                tick();
                chk("t1_hs_drop", 32'(out_valid), 32'd0);
                chk("t1_busy_mid", 32'(busy), 32'd1);
            end
            tick();
            chk("t1_settle", 32'(out_valid), 32'd0);
            tick();
            chk("t1_valid", 32'(out_valid), 32'd1);
            chk("t1_chan",  32'(out_chan),  32'(k));
            chk("t1_data",  32'(out_data),  32'd1 << k);
        end
        tick();
        chk("t1_done",     32'(done),      32'd1);
        chk("t1_busy_end", 32'(busy),      32'd0);
        chk("t1_val_end",  32'(out_valid), 32'd0);
        chk("t1_sel_keep", 32'(sel),       32'd3);
        tick();
        chk("t1_done_1cy", 32'(done),      32'd0);

        // Sparse mask 1010: only channels 1 and 3
        sel_seen = 4'b0000;
        start_scan(4'b1010);
        wait_beat("t2_b0", 2'd1, 4'b0010);
        tick();
        wait_beat("t2_b1", 2'd3, 4'b1000);
        tick();
        chk("t2_done",     32'(done),     32'd1);
        chk("t2_sel_seen", 32'(sel_seen), 32'b1010);
        tick();

        // Empty mask: done on next edge, nothing else
        start_scan(4'b0000);
        chk("t3_done",  32'(done),      32'd1);
        chk("t3_busy",  32'(busy),      32'd0);
        chk("t3_valid", 32'(out_valid), 32'd0);
        tick();
        chk("t3_done_1cy", 32'(done), 32'd0);
        chk("t3_busy2",    32'(busy), 32'd0);

        // Backpressure on beat 0
        out_ready = 1'b0;
        start_scan(4'b1111);
        wait_beat("t4_b0", 2'd0, 4'b0001);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_hold_valid", 32'(out_valid), 32'd1);
            chk("t4_hold_data",  32'(out_data),  32'd1);
            chk("t4_hold_chan",  32'(out_chan),  32'd0);
            chk("t4_hold_sel",   32'(sel),       32'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("t4_release_valid", 32'(out_valid), 32'd0);
        chk("t4_release_sel",   32'(sel),       32'd1);
        wait_beat("t4_b1", 2'd1, 4'b0010);
        tick();
        wait_beat("t4_b2", 2'd2, 4'b0100);
        tick();
        wait_beat("t4_b3", 2'd3, 4'b1000);
        tick();
        chk("t4_done", 32'(done), 32'd1);
        tick();

        // Input change before sampling edge; mask change and start while busy
        start_scan(4'b1111);
        a = 4'b1111;
        wait_beat("t5_b0", 2'd0, 4'b1111);
        a       = 4'b0001;
        chan_en = 4'b0001;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        wait_beat("t5_b1", 2'd1, 4'b0010);
        tick();
        wait_beat("t5_b2", 2'd2, 4'b0100);
        tick();
        wait_beat("t5_b3", 2'd3, 4'b1000);
        tick();
        chk("t5_done", 32'(done), 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t5_no_extra", 32'(out_valid | busy), 32'd0);
        end

        // Asynchronous reset during HOLD of channel 2
        out_ready = 1'b0;
        start_scan(4'b1111);
        wait_beat("t6_b0", 2'd0, 4'b0001);
        out_ready = 1'b1;
        tick();
        wait_beat("t6_b1", 2'd1, 4'b0010);
        tick();
        out_ready = 1'b0;
        wait_beat("t6_b2", 2'd2, 4'b0100);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_busy",  32'(busy),      32'd0);
        chk("t6_rst_sel",   32'(sel),       32'd0);
        chk("t6_rst_data",  32'(out_data),  32'd0);
        chk("t6_rst_chan",  32'(out_chan),  32'd0);
        chk("t6_rst_done",  32'(done),      32'd0);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t6_quiet", 32'({out_valid, busy, done}), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
